// File: rtl/sl3p_am_pkg.sv
// sl3p_am_pkg: shared state encoding, default parameters and width helper
// for the SL3P TX alignment-marker scheduler (sl3p_am_insert).
package sl3p_am_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_AM    = 2'd3
  } am_state_e;

  localparam int DEF_NUM_LN    = 16;
  localparam int DEF_AM_PERIOD = 16384;
  localparam int DEF_AM_LEN    = 1;
  localparam int DEF_SEQ_W     = 8;

  // AM_LEN is at most 4, so the in-group slot index fits in two bits.
  localparam int AM_LEN_W   = 2;
  // Skew injection delays a lane by 0..3 slots.
  localparam int SKEW_DLY_W = 2;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sl3p_am_delay_line.sv
// sl3p_am_delay_line: slot-qualified delay of one lane's AM flag by 0..3
// transmit slots. History only advances on cycles that offer a slot, so
// the delay is measured in slots rather than clocks. Output is registered
// and reads zero on any cycle without a slot, like the other lanes.
// Only instantiated when SL3P_AM_SKEW_INJECT_EN is defined.
module sl3p_am_delay_line
  import sl3p_am_pkg::*;
(
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  clr,
  input  logic                  adv,
  input  logic                  din,
  input  logic [SKEW_DLY_W-1:0] dly,
  output logic                  dout
);

  logic [2:0] hist_q;
  logic       tap;

  // Pick the flag from dly slots ago; zero delay passes the live flag.
  always_comb begin
    tap = din;
    case (dly)
      2'd1:    tap = hist_q[0];
      2'd2:    tap = hist_q[1];
      2'd3:    tap = hist_q[2];
      default: tap = din;
    endcase
  end

  // Shift history on each offered slot; flush everything when the link drops.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      hist_q <= '0;
      dout   <= 1'b0;
    end else if (clr) begin
      hist_q <= '0;
      dout   <= 1'b0;
    end else if (adv) begin
      hist_q <= {hist_q[1:0], din};
      dout   <= tap;
    end else begin
      dout   <= 1'b0;
    end
  end

endmodule

// File: rtl/sl3p_am_insert.sv
// sl3p_am_insert: TX-side alignment-marker scheduler for the SL3P link.
// Decides per transmit slot whether upstream data or an AM group goes out,
// keeps all lanes marking in the same slot, and numbers the marker groups.
// Every output is registered and describes the slot sampled one cycle ago.
// Optional macro SL3P_AM_SKEW_INJECT_EN adds skew_lane/skew_dly inputs that
// delay one lane's marker by 0..3 slots to exercise the RX deskew fallback.
module sl3p_am_insert
  import sl3p_am_pkg::*;
#(
  parameter int NUM_LN    = DEF_NUM_LN,
  parameter int AM_PERIOD = DEF_AM_PERIOD,
  parameter int AM_LEN    = DEF_AM_LEN,
  parameter int SEQ_W     = DEF_SEQ_W
) (
  input  logic                       clk,
  input  logic                       arst_n,
  input  logic                       enable,
  input  logic                       tx_slot,
`ifdef SL3P_AM_SKEW_INJECT_EN
  input  logic [$clog2(NUM_LN)-1:0]  skew_lane,
  input  logic [SKEW_DLY_W-1:0]      skew_dly,
`endif
  output logic                       din_ready,
  output logic [NUM_LN-1:0]          am_insert,
  output logic [SEQ_W-1:0]           am_seq,
  output logic                       am_first
);

  localparam int                  CNT_W    = cnt_width(AM_PERIOD);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(AM_PERIOD - 1);
  localparam logic [AM_LEN_W-1:0] AM_LAST  = AM_LEN_W'(AM_LEN - 1);

  am_state_e           state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [AM_LEN_W-1:0] am_cnt_q, am_cnt_d;
  logic [SEQ_W-1:0]    seq_q, seq_d;
  logic                din_ready_q, din_ready_d;
  logic                am_first_q, am_first_d;
  logic                am_flag_d;

  // Next-state and next-output logic; enable low overrides everything and
  // returns the block to a cleared IDLE on the next clock.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    am_cnt_d    = am_cnt_q;
    seq_d       = seq_q;
    din_ready_d = 1'b0;
    am_flag_d   = 1'b0;
    am_first_d  = 1'b0;

    if (!enable) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      am_cnt_d = '0;
      seq_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d  = ST_START;
          cnt_d    = '0;
          am_cnt_d = '0;
          seq_d    = '0;
        end

        ST_START: begin
          if (tx_slot) begin
            am_flag_d  = 1'b1;
            am_first_d = 1'b1;
            seq_d      = '0;
            cnt_d      = '0;
            if (AM_LEN == 1) begin
              am_cnt_d = '0;
              state_d  = ST_DATA;
            end else begin
              am_cnt_d = AM_LEN_W'(1);
              state_d  = ST_AM;
            end
          end
        end

        ST_DATA: begin
          if (tx_slot) begin
            din_ready_d = 1'b1;
            if (cnt_q == CNT_LAST) begin
              cnt_d    = '0;
              am_cnt_d = '0;
              state_d  = ST_AM;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end

        ST_AM: begin
          if (tx_slot) begin
            am_flag_d = 1'b1;
            if (am_cnt_q == '0) begin
              seq_d = seq_q + SEQ_W'(1);
            end
            if (am_cnt_q == AM_LAST) begin
              am_cnt_d = '0;
              cnt_d    = '0;
              state_d  = ST_DATA;
            end else begin
              am_cnt_d = am_cnt_q + AM_LEN_W'(1);
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      am_cnt_q    <= '0;
      seq_q       <= '0;
      din_ready_q <= 1'b0;
      am_first_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      am_cnt_q    <= am_cnt_d;
      seq_q       <= seq_d;
      din_ready_q <= din_ready_d;
      am_first_q  <= am_first_d;
    end
  end

  assign din_ready = din_ready_q;
  assign am_seq    = seq_q;
  assign am_first  = am_first_q;

`ifdef SL3P_AM_SKEW_INJECT_EN
  localparam int LANE_W = $clog2(NUM_LN);

  logic [LANE_W-1:0]     skew_lane_q;
  logic [SKEW_DLY_W-1:0] skew_dly_q;

  // Skew settings are only taken while idle so a running link never jumps.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      skew_lane_q <= '0;
      skew_dly_q  <= '0;
    end else if (state_q == ST_IDLE) begin
      skew_lane_q <= skew_lane;
      skew_dly_q  <= skew_dly;
    end
  end

  for (genvar i = 0; i < NUM_LN; i++) begin : g_lane
    logic [SKEW_DLY_W-1:0] lane_dly;
    assign lane_dly = (skew_lane_q == LANE_W'(i)) ? skew_dly_q : '0;

    sl3p_am_delay_line u_dly (
      .clk    (clk),
      .arst_n (arst_n),
      .clr    (!enable),
      .adv    (tx_slot),
      .din    (am_flag_d),
      .dly    (lane_dly),
      .dout   (am_insert[i])
    );
  end
`else
  logic am_flag_q;

  // Single marker flag shared by every lane keeps all lanes identical.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      am_flag_q <= 1'b0;
    end else begin
      am_flag_q <= am_flag_d;
    end
  end

  assign am_insert = {NUM_LN{am_flag_q}};
`endif

endmodule

// File: tb/tb_sl3p_am_insert.sv
// tb_sl3p_am_insert: scoreboard bench for sl3p_am_insert. Two instances share
// one stimulus stream: dut_a (AM_PERIOD=8, AM_LEN=1, SEQ_W=8) and dut_b
// (AM_PERIOD=8, AM_LEN=3, SEQ_W=2), both with NUM_LN=4. A slot-position
// model pushes expected outputs when stimulus is driven; they are popped
// and compared one clock later.
module tb_sl3p_am_insert;

  localparam int PERIOD = 8;

  typedef struct packed {
    logic       din;
    logic [3:0] am;
    logic [7:0] seq;
    logic       first;
  } exp_t;

  logic       clk;
  logic       arst_n;
  logic       enable;
  logic       tx_slot;
  logic [1:0] skew_lane;
  logic [1:0] skew_dly;

  logic       a_din, b_din;
  logic [3:0] a_am, b_am;
  logic [7:0] a_seq;
  logic [1:0] b_seq;
  logic       a_first, b_first;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  exp_t q_a[$];
  exp_t q_b[$];

  int m_active[2];
  int m_pos[2];
  int m_grp[2];
  int m_seq[2];

  logic       capture_en = 1'b0;
  logic [3:0] prev_b_am  = 4'h0;
  int         seq_log[$];

  sl3p_am_insert #(.NUM_LN(4), .AM_PERIOD(PERIOD), .AM_LEN(1), .SEQ_W(8)) dut_a (
    .clk       (clk),
    .arst_n    (arst_n),
    .enable    (enable),
    .tx_slot   (tx_slot),
`ifdef SL3P_AM_SKEW_INJECT_EN
    .skew_lane (skew_lane),
    .skew_dly  (skew_dly),
`endif
    .din_ready (a_din),
    .am_insert (a_am),
    .am_seq    (a_seq),
    .am_first  (a_first)
  );

  sl3p_am_insert #(.NUM_LN(4), .AM_PERIOD(PERIOD), .AM_LEN(3), .SEQ_W(2)) dut_b (
    .clk       (clk),
    .arst_n    (arst_n),
    .enable    (enable),
    .tx_slot   (tx_slot),
`ifdef SL3P_AM_SKEW_INJECT_EN
    .skew_lane (skew_lane),
    .skew_dly  (skew_dly),
`endif
    .din_ready (b_din),
    .am_insert (b_am),
    .am_seq    (b_seq),
    .am_first  (b_first)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_active[k] = 0;
      m_pos[k]    = 0;
      m_grp[k]    = 0;
      m_seq[k]    = 0;
    end
  endtask

  // Slot-position model: a group cycle is am_len marker slots followed by
  // PERIOD data slots; the group count modulo 2^seq_w is the sequence number.
  task automatic model_step(input int k, input int am_len, input int seq_w,
                            input logic en, input logic slot, output exp_t e);
    e = '0;
    if (!en) begin
      m_active[k] = 0;
      m_pos[k]    = 0;
      m_grp[k]    = 0;
      m_seq[k]    = 0;
    end else if (m_active[k] == 0) begin
      m_active[k] = 1;
      m_pos[k]    = 0;
      m_grp[k]    = 0;
      m_seq[k]    = 0;
    end else if (slot) begin
      if (m_pos[k] < am_len) begin
        if (m_pos[k] == 0) m_seq[k] = m_grp[k] % (1 << seq_w);
        e.am    = 4'hF;
        e.first = (m_grp[k] == 0) && (m_pos[k] == 0);
      end else begin
        e.din = 1'b1;
      end
      m_pos[k]++;
      if (m_pos[k] == am_len + PERIOD) begin
        m_pos[k] = 0;
        m_grp[k]++;
      end
    end
    e.seq = 8'(m_seq[k]);
  endtask

  task automatic compareOutputs();
    exp_t ea, eb;
    exp_t oa, ob;
    oa = {a_din, a_am, a_seq, a_first};
    ob = {b_din, b_am, {6'b0, b_seq}, b_first};
    if (q_a.size() > 0) begin
      ea = q_a.pop_front();
      checkOutput($sformatf("dut_a cyc%0d", cyc), 32'(oa), 32'(ea));
    end
    if (q_b.size() > 0) begin
      eb = q_b.pop_front();
      checkOutput($sformatf("dut_b cyc%0d", cyc), 32'(ob), 32'(eb));
    end
    if (capture_en && (b_am != 4'h0) && (prev_b_am == 4'h0)) seq_log.push_back(int'(b_seq));
    prev_b_am = b_am;
  endtask

  task automatic applyStimulus(input logic en, input logic slot);
    exp_t ea, eb;
    enable  = en;
    tx_slot = slot;
    model_step(0, 1, 8, en, slot, ea);
    q_a.push_back(ea);
    model_step(1, 3, 2, en, slot, eb);
    q_b.push_back(eb);
    @(posedge clk);
    #1;
    cyc++;
    compareOutputs();
  endtask

  // Mutual exclusion of data and marker slots, checked on every falling edge.
  always @(negedge clk) begin
    if (arst_n) begin
      checkOutput("mutex_a", {31'b0, a_din & (|a_am)}, 32'd0);
      checkOutput("mutex_b", {31'b0, b_din & (|b_am)}, 32'd0);
    end
  end

  // Main stimulus sequence.
  initial begin
    int   wrap_exp[6];
    logic found;
    wrap_exp  = '{0, 1, 2, 3, 0, 1};
    arst_n    = 1'b0;
    enable    = 1'b0;
    tx_slot   = 1'b0;
    skew_lane = 2'd2;
    skew_dly  = 2'd0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_a", {18'b0, a_din, a_am, a_seq, a_first}, 32'd0);
    checkOutput("reset_b", {24'b0, b_din, b_am, b_seq, b_first}, 32'd0);
    #2;
    arst_n = 1'b1;

    $display("[TB] reset and enable, continuous slots");
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, 1'b1);

    $display("[TB] alternate slot gaps");
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, (i % 2) == 0);

    $display("[TB] disable during second marker slot of dut_b");
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      applyStimulus(1'b1, 1'b1);
      if (m_active[1] != 0 && m_pos[1] == 2) found = 1'b1;
    end
    checkOutput("midgroup_reach", {31'b0, found}, 32'd1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 30; i++) applyStimulus(1'b1, 1'b1);

    $display("[TB] sequence wrap on dut_b");
    applyStimulus(1'b0, 1'b1);
    capture_en = 1'b1;
    for (int i = 0; i < 70; i++) applyStimulus(1'b1, 1'b1);
    capture_en = 1'b0;
    checkOutput("wrap_count", {31'b0, seq_log.size() >= 6}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      if (i < seq_log.size()) checkOutput($sformatf("wrap_seq%0d", i), 32'(seq_log[i]), 32'(wrap_exp[i]));
    end

    $display("[TB] random enable and slot");
    for (int i = 0; i < 300; i++) applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 1) != 0);

    $display("[TB] async reset mid-data");
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      applyStimulus(1'b1, 1'b1);
      if (m_active[0] != 0 && m_pos[0] >= 3) found = 1'b1;
    end
    checkOutput("data_reach", {31'b0, found}, 32'd1);
    checkOutput("pre_reset_din", {31'b0, a_din}, 32'd1);
    #2;
    arst_n = 1'b0;
    #1;
    checkOutput("async_clear_a", {18'b0, a_din, a_am, a_seq, a_first}, 32'd0);
    checkOutput("async_clear_b", {24'b0, b_din, b_am, b_seq, b_first}, 32'd0);
    model_reset();
    q_a.delete();
    q_b.delete();
    #3;
    arst_n = 1'b1;
    for (int i = 0; i < 25; i++) applyStimulus(1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/sl3p_am_insert.md
Name: sl3p_am_insert

Overview:
- TX-side alignment-marker (AM) scheduler for the SL3P multi-lane link; the transmit counterpart of the RX deskew monitor.
- Decides which transmit slots carry data and which carry AMs, so all NUM_LN lanes emit marker groups in the same slot.
- Stalls upstream data during marker slots and supplies a marker sequence number for the AM payload.
- Sits between the TX framer and the per-lane TX gearboxes.

Parameters:
- NUM_LN, 16, number of lanes; legal range 2..32.
- AM_PERIOD, 16384, data slots between consecutive marker groups; must be at least 2.
- AM_LEN, 1, consecutive marker slots per group; legal range 1..4.
- SEQ_W, 8, width of the marker sequence number.

Ports:
- clk  in  1  core clock.
- arst_n  in  1  asynchronous active-low reset.
- enable  in  1  link TX enable; level-sensitive.
- tx_slot  in  1  gearbox offers a transmit slot this cycle.
- din_ready  out  1  the slot sampled last cycle carries upstream data.
- am_insert  out  NUM_LN  per-lane flag: the slot sampled last cycle carries an AM.
- am_seq  out  SEQ_W  sequence number of the current or most recent marker group.
- am_first  out  1  pulses with the first marker group after enable.

Behaviour:
- Reset (arst_n low, asynchronous): state IDLE; din_ready=0; am_insert=0; am_seq=0; am_first=0; slot counter=0.
- All outputs are registered. The value in cycle t+1 describes the tx_slot sampled in cycle t (1-cycle latency).
- If tx_slot=0 at t: din_ready=0 and am_insert=0 at t+1, and no counter or state advances.
- State machine:
  - IDLE: outputs idle. enable=1 goes to START.
  - START: on the first tx_slot, emit an AM group of AM_LEN slots immediately, with am_first=1 on the first of them. Then go to DATA with counter=0.
  - DATA: each tx_slot gives din_ready=1 and counter+1. After the slot that brings counter to AM_PERIOD-1, go to AM. Exactly AM_PERIOD data slots occur between groups.
  - AM: each tx_slot gives am_insert all-ones (all lanes identical) and din_ready=0. After AM_LEN slots, go to DATA with counter=0.
- am_seq:
  - Increments by 1 on the first slot of every group except the post-enable first group, which uses 0.
  - Wraps at 2^SEQ_W-1 to 0.
  - Changes in the same cycle am_insert first rises for that group.
- din_ready and any am_insert bit are never both 1.
- enable deasserted in any state: go to IDLE on the next clock, even mid-group or mid-count. The following cycle has all outputs 0 and the counter cleared.
- On re-enable the sequence restarts at START with am_seq=0 and am_first=1.
- enable toggling while tx_slot=0 follows the same rules: enable is sampled every clock.
- Counter width is clog2(AM_PERIOD). Compare against AM_PERIOD-1; no overflow is possible.

Optional Feature:
- Macro: SL3P_AM_SKEW_INJECT_EN.
- Defined:
  - Adds inputs skew_lane [clog2(NUM_LN)-1:0] and skew_dly [1:0].
  - am_insert[skew_lane] is delayed by skew_dly tx_slots relative to the other lanes, so lab and bench can exercise the RX deskew fallback path.
  - skew_dly=0 gives identical lanes.
  - skew_lane and skew_dly are sampled only in IDLE.
  - din_ready is unaffected.
- Undefined: ports are absent and all lanes are always identical.

Decomposition:
- Package sl3p_am_pkg: state encoding (IDLE, START, DATA, AM), default AM_PERIOD, AM_LEN, SEQ_W, and the clog2-based counter-width function.
- One sub-module: sl3p_am_delay_line. It is a per-lane slot-qualified delay of 0..3 slots, instantiated only under SL3P_AM_SKEW_INJECT_EN.

Test Plan (AM_PERIOD=8, AM_LEN=1, NUM_LN=4, SEQ_W=8 unless stated):
- Reset and enable:
  - Stimulus: hold arst_n low, then release; enable=1 from cycle 5; tx_slot=1 continuously.
  - Response: am_insert=4'hF with am_first=1 and am_seq=0 at cycle 7. Then exactly 8 cycles of din_ready=1. Then am_insert=4'hF with am_seq=1. The pattern repeats every 9 cycles.
- Slot gaps:
  - Stimulus: tx_slot=1 on alternate cycles.
  - Response: no outputs asserted in cycles after tx_slot=0. The group still follows exactly 8 qualified data slots.
- Disable mid-group:
  - Stimulus: AM_LEN=3; enable drops during the 2nd AM slot.
  - Response: all outputs 0 from the next clock. On re-enable, am_seq=0 and am_first=1.
- Sequence wrap:
  - Stimulus: SEQ_W=2; run 6 groups.
  - Response: am_seq follows 0,1,2,3,0,1.
- Mutual exclusion and async reset:
  - Random tx_slot and enable: an assertion holds that din_ready and |am_insert are never both 1.
  - arst_n pulsed mid-DATA: outputs clear without a clock edge.
- Skew inject (macro defined):
  - Stimulus: skew_lane=2, skew_dly=2.
  - Response: am_insert[2] rises 2 slots after am_insert[0,1,3]; all other timing is unchanged.
